// File: rtl/frost32_mem_arbiter.sv
// Round-robin arbiter folding NUM_CH requesters onto one Frost32 memory port, with alignment
// checks, byte enables and lane steering. Define FROST32_MEM_ARB_TIMEOUT_EN for the wait watchdog.
module frost32_mem_arbiter #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*32-1:0]         ch_wdata,
  input  logic [NUM_CH-1:0]            ch_access_type,
  input  logic [NUM_CH*2-1:0]          ch_access_size,
  output logic [NUM_CH-1:0]            ch_done,
  output logic [NUM_CH-1:0]            ch_err,
  output logic [31:0]                  ch_rdata,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic                         mem_access_type,
  output logic [1:0]                   mem_access_size,
  output logic [3:0]                   mem_byte_en,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata,
  input  logic                         mem_wait,
  output logic                         busy
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] Dias32 = 2'd0;
  localparam logic [1:0] Dias16 = 2'd1;
  localparam logic [1:0] Dias8  = 2'd2;

  typedef enum logic [1:0] {StIdle, StAccess, StRespErr} state_e;

  state_e                  state_q, state_d;
  // Pointer doubles as the current winner once a grant is made.
  logic [ChW-1:0]          ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    type_q, type_d;
  logic [1:0]              size_q, size_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [NUM_CH-1:0]       done_q, done_d;
  logic [NUM_CH-1:0]       err_q, err_d;

  logic [NUM_CH-1:0]       req_masked;
  logic                    grant_vld;
  logic [ChW-1:0]          grant_idx;
  logic [ChW-1:0]          cand;
  int unsigned             idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [31:0]             sel_wdata;
  logic                    sel_type;
  logic [1:0]              sel_size;
  logic                    sel_legal;
  logic [31:0]             rd_lane;
  logic                    tmo_hit;

  // Search upward from ptr+1; the last winner is considered last.
  always_comb begin
    req_masked = ch_req & ~(done_q | err_q);
    grant_vld  = 1'b0;
    grant_idx  = ptr_q;
    idx        = 0;
    cand       = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      idx  = (32'(ptr_q) + off) % NUM_CH;
      cand = ChW'(idx);
      if (!grant_vld && req_masked[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = ch_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = ch_wdata[grant_idx*32 +: 32];
    sel_type  = ch_access_type[grant_idx];
    sel_size  = ch_access_size[grant_idx*2 +: 2];
    case (sel_size)
      Dias32:  sel_legal = (sel_addr[1:0] == 2'b00);
      Dias16:  sel_legal = !sel_addr[0];
      Dias8:   sel_legal = 1'b1;
      default: sel_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (size_q)
      Dias8:   rd_lane = (mem_rdata >> {addr_q[1:0], 3'b000}) & 32'h0000_00ff;
      Dias16:  rd_lane = (mem_rdata >> {addr_q[1:0], 3'b000}) & 32'h0000_ffff;
      default: rd_lane = mem_rdata;
    endcase
  end

`ifdef FROST32_MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 16) ? 16 : CntRaw);

  logic [CntW-1:0] tmo_q, tmo_d;

  // Held at zero outside ACCESS so every access starts from a clean count.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != StAccess) begin
      tmo_d = '0;
    end else if (mem_wait) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  assign tmo_hit = mem_wait && (tmo_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= ChW'(NUM_CH - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= 1'b0;
      size_q  <= 2'b00;
      rdata_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      type_q  <= type_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    type_d  = type_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    done_d  = '0;
    err_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          ptr_d   = grant_idx;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          type_d  = sel_type;
          size_d  = sel_size;
          state_d = sel_legal ? StAccess : StRespErr;
        end
      end
      StAccess: begin
        if (!mem_wait) begin
          done_d[ptr_q] = 1'b1;
          if (!type_q) begin
            rdata_d = rd_lane;
          end
          state_d = StIdle;
        end else if (tmo_hit) begin
          err_d[ptr_q] = 1'b1;
          state_d      = StIdle;
        end
      end
      StRespErr: begin
        err_d[ptr_q] = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory-side fields are zeroed whenever no access is in flight.
  always_comb begin
    mem_req         = (state_q == StAccess);
    busy            = (state_q != StIdle);
    mem_addr        = '0;
    mem_access_type = 1'b0;
    mem_access_size = 2'b00;
    mem_byte_en     = 4'b0000;
    mem_wdata       = '0;
    if (mem_req) begin
      mem_addr        = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      mem_access_type = type_q;
      mem_access_size = size_q;
      case (size_q)
        Dias16: begin
          mem_byte_en = 4'b0011 << addr_q[1:0];
          mem_wdata   = {2{wdata_q[15:0]}};
        end
        Dias8: begin
          mem_byte_en = 4'b0001 << addr_q[1:0];
          mem_wdata   = {4{wdata_q[7:0]}};
        end
        default: begin
          mem_byte_en = 4'b1111;
          mem_wdata   = wdata_q;
        end
      endcase
    end
    ch_done  = done_q;
    ch_err   = err_q;
    ch_rdata = rdata_q;
  end

endmodule
